// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO register pair.
//   hilo_state_e - FSM state encodings (IDLE/BUSY/DRAIN)
//   hilo_cnt_w   - width of the BUSY/DRAIN watchdog counter for a given TIMEOUT
package hilo_pkg;

  typedef enum logic [1:0] {
    HILO_IDLE  = 2'd0,
    HILO_BUSY  = 2'd1,
    HILO_DRAIN = 2'd2
  } hilo_state_e;

  // Counter only has to reach TIMEOUT-1; keep at least one bit.
  function automatic int hilo_cnt_w(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/hilo_field_reg.sv
// hilo_field_reg: one architectural word (HI or LO).
//   clk, resetn  clock, async active-low reset (clears q)
//   squashn      0 = ignore wr_en this cycle
//   wr_en        mthi/mtlo write of wr_data
//   res_en       arithmetic result load of res_data (not subject to squash)
//   q            current register value
module hilo_field_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             squashn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             res_en,
  input  logic [WIDTH-1:0] res_data,
  output logic [WIDTH-1:0] q
);

  // res_en and wr_en are mutually exclusive in the parent (BUSY vs IDLE);
  // result takes priority only as a tie-break.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (res_en) begin
      q <= res_data;
    end else if (wr_en && squashn) begin
      q <= wr_data;
    end
  end

endmodule

// File: rtl/hilo_pair_reg.sv
// hilo_pair_reg: HI/LO register pair for the multiply/divide path.
//   Tracks one in-flight mul/div op, stalls dependent accesses, discards
//   results of flushed ops and aborts via a watchdog if a result never comes.
// Optional feature: define HILO_FWD_EN to bypass a completing result
//   straight to rd_data so a read in the completion cycle does not stall.
// Ports:
//   clk, resetn        clock, async active-low reset
//   squashn            0 = squash wr_hi_en/wr_lo_en/issue_en this cycle
//   flush              cancel the in-flight op
//   issue_en           mul/div op issued
//   wr_hi_en/wr_lo_en  mthi/mtlo of wr_data
//   res_valid          result strobe with res_hi/res_lo
//   rd_en, rd_sel      mfhi/mflo request, 0 = LO, 1 = HI
//   rd_data            selected register (combinational)
//   stall              hold requester (combinational)
//   busy               op outstanding (registered)
//   err                sticky watchdog-abort flag
module hilo_pair_reg
  import hilo_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             squashn,
  input  logic             flush,
  input  logic             issue_en,
  input  logic             wr_hi_en,
  input  logic             wr_lo_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_hi,
  input  logic [WIDTH-1:0] res_lo,
  input  logic             rd_en,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             stall,
  output logic             busy,
  output logic             err
);

  localparam int          CW       = hilo_cnt_w(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  hilo_state_e    state;
  logic [CW-1:0]  count;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic idle;
  logic res_load;
  logic fwd_hit;
  logic wd_expire;

  assign idle      = (state == HILO_IDLE);
  assign res_load  = (state == HILO_BUSY) && res_valid && !flush;
  assign wd_expire = !idle && (count == CNT_LAST);

`ifdef HILO_FWD_EN
  assign fwd_hit = res_load;
`else
  assign fwd_hit = 1'b0;
`endif

  // Non-IDLE requests are held off; a read alone may pass when the
  // completing result can be bypassed.
  always_comb begin
    stall = 1'b0;
    if (!idle && squashn) begin
      stall = (rd_en && !fwd_hit) || wr_hi_en || wr_lo_en || issue_en;
    end
  end

  always_comb begin
    rd_data = rd_sel ? hi_q : lo_q;
    if (fwd_hit) begin
      rd_data = rd_sel ? res_hi : res_lo;
    end
  end

  // mthi/mtlo only take effect in IDLE; outside IDLE they are stalled.
  hilo_field_reg #(.WIDTH(WIDTH)) u_hi (
    .clk      (clk),
    .resetn   (resetn),
    .squashn  (squashn),
    .wr_en    (wr_hi_en && idle),
    .wr_data  (wr_data),
    .res_en   (res_load),
    .res_data (res_hi),
    .q        (hi_q)
  );

  hilo_field_reg #(.WIDTH(WIDTH)) u_lo (
    .clk      (clk),
    .resetn   (resetn),
    .squashn  (squashn),
    .wr_en    (wr_lo_en && idle),
    .wr_data  (wr_data),
    .res_en   (res_load),
    .res_data (res_lo),
    .q        (lo_q)
  );

  // A result arriving on the watchdog's last cycle is still applied (the
  // data path above does not look at the watchdog); err is set regardless.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= HILO_IDLE;
      count <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (wd_expire) begin
        err <= 1'b1;
      end
      case (state)
        HILO_IDLE: begin
          if (issue_en && squashn) begin
            state <= HILO_BUSY;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        HILO_BUSY: begin
          if (res_valid || wd_expire) begin
            state <= HILO_IDLE;
            busy  <= 1'b0;
          end else if (flush) begin
            state <= HILO_DRAIN;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        HILO_DRAIN: begin
          if (res_valid || wd_expire) begin
            state <= HILO_IDLE;
            busy  <= 1'b0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= HILO_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_pair_reg.sv
// Scoreboard bench for hilo_pair_reg (WIDTH=32, TIMEOUT=8).
module tb_hilo_pair_reg;

`ifdef HILO_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        squashn;
  logic        flush;
  logic        issue_en;
  logic        wr_hi_en;
  logic        wr_lo_en;
  logic [31:0] wr_data;
  logic        res_valid;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        rd_en;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        stall;
  logic        busy;
  logic        err;

  hilo_pair_reg #(.WIDTH(32), .TIMEOUT(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .squashn   (squashn),
    .flush     (flush),
    .issue_en  (issue_en),
    .wr_hi_en  (wr_hi_en),
    .wr_lo_en  (wr_lo_en),
    .wr_data   (wr_data),
    .res_valid (res_valid),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .rd_en     (rd_en),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .stall     (stall),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] rd;
    logic        st;
    logic        bz;
    logic        er;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   done   = 1'b0;

  // Monitor: at each falling edge, check every expectation tagged for this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (e.cyc != cyc) begin
        n_miss++;
        $display("FAIL %s: not sampled in its cycle (tag %0d, now %0d)", e.name, e.cyc, cyc);
      end else if (rd_data !== e.rd || stall !== e.st || busy !== e.bz || err !== e.er) begin
        n_miss++;
        $display("FAIL %s: got rd_data=%h stall=%b busy=%b err=%b, expected rd_data=%h stall=%b busy=%b err=%b",
                 e.name, rd_data, stall, busy, err, e.rd, e.st, e.bz, e.er);
      end
    end
  end

  task automatic expect_out(input string name, input logic [31:0] rd,
                            input logic st, input logic bz, input logic er);
    exp_t e;
    e.cyc = cyc; e.name = name; e.rd = rd; e.st = st; e.bz = bz; e.er = er;
    q.push_back(e);
  endtask

  // Advance to just after the next rising edge and drop all pulse inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    squashn = 1'b1; flush = 1'b0; issue_en = 1'b0;
    wr_hi_en = 1'b0; wr_lo_en = 1'b0; wr_data = '0;
    res_valid = 1'b0; res_hi = '0; res_lo = '0;
    rd_en = 1'b0; rd_sel = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; squashn = 1'b1; flush = 1'b0; issue_en = 1'b0;
    wr_hi_en = 1'b0; wr_lo_en = 1'b0; wr_data = '0;
    res_valid = 1'b0; res_hi = '0; res_lo = '0;
    rd_en = 1'b0; rd_sel = 1'b0;

    tick(); expect_out("reset", 32'h0, 0, 0, 0);
    resetn = 1'b1;

    // 1: mtlo
    tick(); wr_lo_en = 1; wr_data = 32'h1234; expect_out("t1_pre", 32'h0, 0, 0, 0);
    tick(); rd_en = 1; rd_sel = 0; expect_out("t1_lo", 32'h1234, 0, 0, 0);
    tick(); rd_en = 1; rd_sel = 1; expect_out("t1_hi", 32'h0, 0, 0, 0);

    // 2: issue, stalled reads, result
    tick(); issue_en = 1; expect_out("t2_issue", 32'h1234, 0, 0, 0);
    tick(); rd_en = 1; rd_sel = 1; expect_out("t2_stall1", 32'h0, 1, 1, 0);
    tick(); rd_en = 1; rd_sel = 1; expect_out("t2_stall2", 32'h0, 1, 1, 0);
    tick(); res_valid = 1; res_hi = 32'hAAAA0000; res_lo = 32'h5555; rd_sel = 1;
    expect_out("t2_res", FWD ? 32'hAAAA0000 : 32'h0, 0, 1, 0);
    tick(); rd_en = 1; rd_sel = 1; expect_out("t2_hi", 32'hAAAA0000, 0, 0, 0);
    tick(); rd_en = 1; rd_sel = 0; expect_out("t2_lo", 32'h5555, 0, 0, 0);

    // 3: flush -> DRAIN, late result discarded
    tick(); issue_en = 1; expect_out("t3_issue", 32'h5555, 0, 0, 0);
    tick(); flush = 1; expect_out("t3_flush", 32'h5555, 0, 1, 0);
    tick(); expect_out("t3_drain", 32'h5555, 0, 1, 0);
    tick(); expect_out("t3_drain2", 32'h5555, 0, 1, 0);
    tick(); res_valid = 1; res_hi = 32'hFFFF; res_lo = 32'hEEEE;
    expect_out("t3_res", 32'h5555, 0, 1, 0);
    tick(); rd_en = 1; rd_sel = 1; expect_out("t3_hi", 32'hAAAA0000, 0, 0, 0);
    tick(); rd_en = 1; rd_sel = 0; expect_out("t3_lo", 32'h5555, 0, 0, 0);

    // flush together with result in BUSY: discarded, straight to IDLE
    tick(); issue_en = 1; expect_out("fr_issue", 32'h5555, 0, 0, 0);
    tick(); flush = 1; res_valid = 1; res_lo = 32'h1111; res_hi = 32'h2222;
    expect_out("fr_both", 32'h5555, 0, 1, 0);
    tick(); expect_out("fr_idle", 32'h5555, 0, 0, 0);

    // 5: squash
    tick(); squashn = 0; wr_hi_en = 1; wr_data = 32'hDEAD; rd_sel = 1;
    expect_out("t5_sqwr", 32'hAAAA0000, 0, 0, 0);
    tick(); squashn = 0; issue_en = 1; rd_sel = 1; expect_out("t5_sqis", 32'hAAAA0000, 0, 0, 0);
    tick(); rd_sel = 1; expect_out("t5_after", 32'hAAAA0000, 0, 0, 0);

    // both writes at once
    tick(); wr_hi_en = 1; wr_lo_en = 1; wr_data = 32'hCAFE;
    expect_out("both_wr", 32'h5555, 0, 0, 0);
    tick(); rd_sel = 1; expect_out("both_hi", 32'hCAFE, 0, 0, 0);
    tick(); rd_sel = 0; expect_out("both_lo", 32'hCAFE, 0, 0, 0);

    // issue + write same cycle; a write during BUSY stalls and is dropped
    tick(); issue_en = 1; wr_lo_en = 1; wr_data = 32'h0BAD;
    expect_out("iw_issue", 32'hCAFE, 0, 0, 0);
    tick(); rd_sel = 0; expect_out("iw_lo", 32'h0BAD, 0, 1, 0);
    tick(); wr_hi_en = 1; wr_data = 32'h1; rd_sel = 1; expect_out("iw_wrstall", 32'hCAFE, 1, 1, 0);
    tick(); res_valid = 1; res_hi = 32'h2; res_lo = 32'h3; rd_sel = 1;
    expect_out("iw_res", FWD ? 32'h2 : 32'hCAFE, 0, 1, 0);
    tick(); rd_sel = 1; expect_out("iw_hi", 32'h2, 0, 0, 0);
    tick(); rd_sel = 0; expect_out("iw_lo2", 32'h3, 0, 0, 0);

    // 6: read in the completion cycle
    tick(); issue_en = 1; expect_out("t6_issue", 32'h3, 0, 0, 0);
    tick(); rd_en = 1; rd_sel = 1; res_valid = 1; res_hi = 32'hBEEF; res_lo = 32'h0;
    expect_out("t6_fwd", FWD ? 32'hBEEF : 32'h2, FWD ? 1'b0 : 1'b1, 1, 0);
    tick(); rd_en = 1; rd_sel = 1; expect_out("t6_next", 32'hBEEF, 0, 0, 0);

    // 4: watchdog, TIMEOUT=8
    tick(); issue_en = 1; expect_out("t4_issue", 32'h0, 0, 0, 0);
    tick(); expect_out("t4_c1", 32'h0, 0, 1, 0);
    for (int i = 2; i <= 7; i++) tick();
    tick(); expect_out("t4_c8", 32'h0, 0, 1, 0);
    tick(); expect_out("t4_abort", 32'h0, 0, 0, 1);
    tick(); rd_sel = 1; expect_out("t4_sticky", 32'hBEEF, 0, 0, 1);

    // reset mid-op; a later result is ignored
    tick(); issue_en = 1; expect_out("rm_issue", 32'h0, 0, 0, 1);
    tick(); expect_out("rm_busy", 32'h0, 0, 1, 1);
    tick(); resetn = 0; rd_sel = 1; expect_out("rm_reset", 32'h0, 0, 0, 0);
    tick(); resetn = 1; res_valid = 1; res_hi = 32'h66; res_lo = 32'h77;
    expect_out("rm_lateres", 32'h0, 0, 0, 0);
    tick(); rd_sel = 1; expect_out("rm_hi", 32'h0, 0, 0, 0);
    tick(); rd_sel = 0; expect_out("rm_lo", 32'h0, 0, 0, 0);

    tick(); tick();
    @(posedge clk); #1;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
